// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (subtractor today, adder later).
package serial_arith_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell built from gate primitives: d = x - y - bin, bout = borrow out.
module full_subtractor (
    input  wire x,
    input  wire y,
    input  wire bin,
    output wire d,
    output wire bout
);

    wire x_n;
    wire xy;
    wire xy_n;
    wire br_xy;
    wire br_in;

    xor g_xor0 (xy, x, y);
    xor g_xor1 (d, xy, bin);
    not g_not0 (x_n, x);
    not g_not1 (xy_n, xy);
    and g_and0 (br_xy, x_n, y);
    and g_and1 (br_in, xy_n, bin);
    or  g_or0  (bout, br_xy, br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock; result word and flags are
// presented all at once on completion and held until the next accepted start.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   d_sr_q, d_sr_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bor_q, bor_d;
    logic               borrow_q, borrow_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fs_d;
    logic               fs_bout;

    full_subtractor u_fs (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (bor_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // Next-state, datapath and output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        d_sr_d   = d_sr_q;
        diff_d   = diff_q;
        bor_d    = bor_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    d_sr_d  = '0;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                d_sr_d = {fs_d, d_sr_q[WIDTH-1:1]};
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                bor_d  = fs_bout;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // MSB cell: overflow is borrow-in XOR borrow-out of the sign bit
                    diff_d   = {fs_d, d_sr_q[WIDTH-1:1]};
                    borrow_d = fs_bout;
                    ovf_d    = bor_q ^ fs_bout;
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            d_sr_q   <= '0;
            diff_q   <= '0;
            bor_q    <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            d_sr_q   <= d_sr_d;
            diff_q   <= diff_d;
            bor_q    <= bor_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing diff = a - b over WIDTH clock cycles, one bit per cycle, LSB first.
- Built around a single combinational full-subtractor cell plus a registered borrow: the subtract-direction counterpart of the team's gate-level full adder.
- Used in area-constrained datapaths where a WIDTH-bit parallel subtractor is not justified; start/done handshake toward a controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled on a rising edge only when the block is not busy
- a  input  WIDTH  minuend; sampled together with an accepted start
- b  input  WIDTH  subtrahend; sampled together with an accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result becomes valid
- diff  output  WIDTH  a - b modulo 2^WIDTH; held until the next accepted start
- borrow  output  1  unsigned borrow (1 when a < b unsigned); held with diff
- ovf  output  1  signed overflow of a - b; held with diff

Behaviour:
- Reset: synchronous, active-low; sampled only on a clk rising edge.
  - While rst_n=0: state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0, bit counter=0, internal operand shift registers=0, borrow flop=0.
  - start asserted on a cycle with rst_n=0 is ignored.
  - Reset during SHIFT aborts the operation; no done pulse is issued.
- States: IDLE, SHIFT, DONE. The encoding is a localparam in the shared package.
  - IDLE/DONE + start=1: latch a and b into shift registers, clear the borrow flop, counter=0, go to SHIFT.
  - SHIFT: each cycle apply full_subtractor to (a_sr[0], b_sr[0], borrow flop).
    - Shift the diff register right, inserting the difference bit at the MSB.
    - Shift a_sr and b_sr right.
    - Borrow flop <= bout; counter increments.
  - SHIFT, counter = WIDTH-1: last bit processed. Update borrow <= bout and ovf <= bin XOR bout (borrow into MSB XOR borrow out of MSB). Go to DONE.
  - DONE: lasts exactly one cycle, then returns to IDLE unless start=1, which is accepted exactly as in IDLE.
- busy=1 exactly in SHIFT. done=1 exactly in DONE. Both are registered outputs.
- Latency: start accepted at edge k → busy high after k through k+WIDTH-1 → done high during the cycle after edge k+WIDTH → results valid from that same edge.
  - Back-to-back throughput: one result per WIDTH+1 cycles.
- start while busy: ignored; a/b are not resampled; the current operation is unaffected.
- diff, borrow and ovf are not updated during SHIFT.
  - They hold the previous result until edge k+WIDTH, at which the full new word is presented.
  - diff is therefore assembled in a separate internal shift register, copied at completion.
- Arithmetic: modulo 2^WIDTH, no saturation.
- Counter width: $clog2(WIDTH). Wrap beyond WIDTH-1 must not occur.

Decomposition:
- Shared package (serial_arith_pkg): state localparams IDLE/SHIFT/DONE and the state-register width. It is reusable by a future serial_adder.
- Sub-module full_subtractor: purely combinational.
  - Inputs: x, y, bin. Outputs: d, bout.
  - d = x XOR y XOR bin; bout = (NOT x AND y) OR (NOT (x XOR y) AND bin).
  - Gate-level primitives only, matching the existing adder cell style.
- Top-level: FSM, counter, three shift registers, result/flag registers.

Test Plan:
- WIDTH=8, a=100, b=58, start one cycle → busy for 8 cycles, then done pulse; diff=8'd42, borrow=0, ovf=0.
- a=8'd5, b=8'd7 → diff=8'hFE, borrow=1, ovf=0. a=8'h80, b=8'h01 → diff=8'h7F, borrow=0, ovf=1.
- a=8'h00, b=8'h00 → diff=0, borrow=0, ovf=0. a=8'h00, b=8'hFF → diff=8'h01, borrow=1, ovf=0.
- Start accepted with a=10, b=3. Pulse start with a=200, b=1 on cycle 4 while busy → ignored; done once with diff=7. Previous diff is stable throughout busy.
- Start accepted. rst_n=0 on cycle 3 for one cycle → all outputs 0, no done pulse. A new start after reset completes normally.
- start held high continuously with new operands each DONE cycle → results every 9 cycles, each matching a - b.
- Randomised check against the a - b reference model for WIDTH=8 and WIDTH=5.
